// File: rtl/me_pkg.sv
// me_pkg: shared sizing helpers and formatter state encodings for the motion-estimation datapath
package me_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] BCD  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    function automatic int calc_n(input int tb_length, input int sw_length);
        return sw_length - tb_length + 1;
    endfunction

    function automatic int calc_cnt_width(input int n);
        return $clog2(n * n);
    endfunction

    function automatic int calc_sad_width(input int tb_length, input int pe_out_width);
        return $clog2(tb_length ** 2) + pe_out_width;
    endfunction

    function automatic int calc_mv_width(input int n);
        return $clog2(n) + 1;
    endfunction

    // ceil(w*log10(2)) in fixed point
    function automatic int calc_bcd_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one shift per cycle for W cycles after start
module bin2bcd_seq
    import me_pkg::*;
#(
    parameter int W = 16,
    localparam int D = calc_bcd_digits(W)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           start,
    input  logic [W-1:0]   bin,
    output logic           done,
    output logic [4*D-1:0] bcd
);

    logic [W+4*D-1:0]     work, adj;
    logic [$clog2(W)-1:0] cnt;
    logic                 run;

    always_comb begin
        adj = work;
        for (int i = 0; i < D; i++)
            if (work[W+4*i +: 4] >= 4'd5) adj[W+4*i +: 4] = work[W+4*i +: 4] + 4'd3;
    end

    assign done = run && cnt == $bits(cnt)'(W - 1);
    assign bcd  = work[W +: 4*D];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
            cnt  <= '0;
            run  <= 1'b0;
        end else if (clr) begin
            run  <= 1'b0;
        end else if (start) begin
            work <= {{(4*D){1'b0}}, bin};
            cnt  <= '0;
            run  <= 1'b1;
        end else if (run) begin
            work <= adj << 1;
            cnt  <= cnt + 1'b1;
            run  <= !done;
        end
    end

endmodule

// File: rtl/me_result_formatter.sv
// me_result_formatter: turns me_top best-match index/SAD into a centred signed motion vector and packed BCD,
// held stable for the display until the next search or a clear
module me_result_formatter
    import me_pkg::*;
#(
    parameter int TB_LENGTH    = 16,
    parameter int SW_LENGTH    = 64,
    parameter int PE_OUT_WIDTH = 8,
    localparam int N          = calc_n(TB_LENGTH, SW_LENGTH),
    localparam int CNT_WIDTH  = calc_cnt_width(N),
    localparam int SAD_WIDTH  = calc_sad_width(TB_LENGTH, PE_OUT_WIDTH),
    localparam int MV_WIDTH   = calc_mv_width(N),
    localparam int BCD_DIGITS = calc_bcd_digits(SAD_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ack,
    input  logic [CNT_WIDTH-1:0]       min_cnt,
    input  logic [SAD_WIDTH-1:0]       min_sad,
    input  logic                       clr,
    output logic signed [MV_WIDTH-1:0] mv_x,
    output logic signed [MV_WIDTH-1:0] mv_y,
    output logic [4*BCD_DIGITS-1:0]    sad_bcd,
    output logic                       busy,
    output logic                       valid,
    output logic                       err
);

    localparam logic [CNT_WIDTH-1:0] NC    = CNT_WIDTH'(N);
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(N * N);
    localparam logic [MV_WIDTH-1:0]  HALF  = MV_WIDTH'((N - 1) / 2);

    logic [1:0]                  state;
    logic                        ack_d;
    logic [CNT_WIDTH-1:0]        rem;
    logic [MV_WIDTH-1:0]         q;
    logic [SAD_WIDTH-1:0]        sad;
    logic [4*BCD_DIGITS-1:0]     bcd;
    logic                        bcd_start, bcd_done, trigger;

    assign trigger   = ack && !ack_d;
    assign bcd_start = state == DIV && rem < NC;

    bin2bcd_seq #(.W(SAD_WIDTH)) u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .start (bcd_start),
        .bin   (sad),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ack_d   <= 1'b0;
            rem     <= '0;
            q       <= '0;
            sad     <= '0;
            mv_x    <= '0;
            mv_y    <= '0;
            sad_bcd <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            ack_d <= ack;
            if (clr) begin
                state   <= IDLE;
                mv_x    <= '0;
                mv_y    <= '0;
                sad_bcd <= '0;
                busy    <= 1'b0;
                valid   <= 1'b0;
                err     <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (trigger) begin
                        rem   <= min_cnt;
                        sad   <= min_sad;
                        q     <= '0;
                        busy  <= 1'b1;
                        valid <= 1'b0;
                        if (min_cnt >= LIMIT) begin
                            err     <= 1'b1;
                            mv_x    <= '0;
                            mv_y    <= '0;
                            sad_bcd <= '0;
                            state   <= DONE;
                        end else begin
                            err   <= 1'b0;
                            state <= DIV;
                        end
                    end
                    DIV: if (rem >= NC) begin
                        rem <= rem - NC;
                        q   <= q + 1'b1;
                    end else begin
                        state <= BCD;
                    end
                    BCD: if (bcd_done) state <= DONE;
                    DONE: begin
                        // an out-of-range index keeps the zeros cleared at capture
                        if (!err) begin
                            mv_x    <= rem[MV_WIDTH-1:0] - HALF;
                            mv_y    <= q - HALF;
                            sad_bcd <= bcd;
                        end
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_me_result_formatter.sv
// tb_me_result_formatter: directed checks of vector mapping, BCD, latency, err, clr and async reset
module tb_me_result_formatter;

    logic              clk = 1'b0;
    logic              rst_n, ack, clr;
    logic [11:0]       min_cnt;
    logic [15:0]       min_sad;
    logic signed [6:0] mv_x, mv_y;
    logic [19:0]       sad_bcd;
    logic              busy, valid, err;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    me_result_formatter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ack     (ack),
        .min_cnt (min_cnt),
        .min_sad (min_sad),
        .clr     (clr),
        .mv_x    (mv_x),
        .mv_y    (mv_y),
        .sad_bcd (sad_bcd),
        .busy    (busy),
        .valid   (valid),
        .err     (err)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input int x, input int y, input logic [19:0] b,
                        input logic e, input logic v);
        check({tag, "_mv_x"}, mv_x, x);
        check({tag, "_mv_y"}, mv_y, y);
        check({tag, "_bcd"}, sad_bcd, b);
        check({tag, "_err"}, err, e);
        check({tag, "_valid"}, valid, v);
        check({tag, "_busy"}, busy, 0);
    endtask

    // raises ack and counts edges, trigger edge included, until valid is seen
    task automatic conv(input string tag, input logic [11:0] c, input logic [15:0] s,
                        input int exp_lat, input bit glitch);
        int lat = 1;
        min_cnt = c;
        min_sad = s;
        ack = 1'b1;
        tick(1);
        check({tag, "_busy_start"}, busy, 1);
        while (!valid && lat < 100) begin
            if (glitch && lat == 3) ack = 1'b0;
            if (glitch && lat == 5) begin
                ack = 1'b1;
                min_cnt = 12'd0;
                min_sad = 16'd5;
            end
            tick(1);
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        rst_n = 1'b0; ack = 1'b0; clr = 1'b0; min_cnt = '0; min_sad = '0;
        tick(2);
        outs("reset", 0, 0, 20'h0, 0, 0);
        rst_n = 1'b1;
        tick(1);
        outs("idle", 0, 0, 20'h0, 0, 0);

        conv("zero", 12'd0, 16'd0, 19, 0);
        outs("zero", -24, -24, 20'h00000, 0, 1);
        ack = 1'b0; tick(1);

        conv("centre", 12'd1200, 16'd1234, 43, 0);
        outs("centre", 0, 0, 20'h01234, 0, 1);
        ack = 1'b0; tick(1);

        conv("worst", 12'd2400, 16'd65280, 67, 0);
        outs("worst", 24, 24, 20'h65280, 0, 1);
        ack = 1'b0; tick(1);

        // row 5, col 7; second pulse and operand change while busy must be ignored
        conv("hold", 12'd252, 16'd999, 24, 1);
        outs("hold", -17, -19, 20'h00999, 0, 1);
        tick(200);
        outs("hold200", -17, -19, 20'h00999, 0, 1);
        ack = 1'b0; tick(1);

        conv("range", 12'd2401, 16'd77, 2, 0);
        outs("range", 0, 0, 20'h0, 1, 1);
        ack = 1'b0; tick(1);

        conv("edge", 12'd48, 16'd5, 19, 0);
        outs("edge", 24, -24, 20'h00005, 0, 1);
        ack = 1'b0; tick(1);

        min_cnt = 12'd2400; min_sad = 16'd321; ack = 1'b1;
        tick(10);
        check("mid_div_busy", busy, 1);
        clr = 1'b1; tick(1); clr = 1'b0;
        outs("clr_div", 0, 0, 20'h0, 0, 0);
        tick(80);
        outs("clr_div_hold", 0, 0, 20'h0, 0, 0);
        ack = 1'b0; tick(1);

        conv("after_clr", 12'd1200, 16'd1234, 43, 0);
        outs("after_clr", 0, 0, 20'h01234, 0, 1);
        ack = 1'b0; tick(1);

        min_cnt = 12'd0; ack = 1'b1; clr = 1'b1;
        tick(1); clr = 1'b0;
        outs("clr_trig", 0, 0, 20'h0, 0, 0);
        tick(80);
        outs("clr_trig_hold", 0, 0, 20'h0, 0, 0);
        ack = 1'b0; tick(1);

        conv("pre_rst", 12'd2400, 16'd65280, 67, 0);
        ack = 1'b0; tick(1);
        min_cnt = 12'd0; min_sad = 16'd4321; ack = 1'b1;
        tick(5);
        check("mid_bcd_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        outs("async_rst", 0, 0, 20'h0, 0, 0);
        ack = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        outs("post_rst", 0, 0, 20'h0, 0, 0);

        conv("recover", 12'd0, 16'd4321, 19, 0);
        outs("recover", -24, -24, 20'h04321, 0, 1);
        ack = 1'b0; tick(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
